// File: rtl/pkt_len_histogram.sv
// Passive AXI-Stream packet-length histogram: sorts completed packets into
// programmable length bins and keeps other/oversize/total packet and byte counters.
module pkt_len_histogram #(
  parameter int unsigned DW    = 512,
  parameter int unsigned NBINS = 4,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 64
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [DW-1:0]            monitor_tdata,
  input  logic [DW/8-1:0]          monitor_tkeep,
  input  logic                     monitor_tlast,
  input  logic                     monitor_tvalid,
  input  logic                     monitor_tready,
  input  logic [NBINS*LEN_W-1:0]   bin_len,
  input  logic                     clear_counters,
  output logic [NBINS*CNT_W-1:0]   bin_packets,
  output logic [CNT_W-1:0]         other_packets,
  output logic [CNT_W-1:0]         oversize_packets,
  output logic [CNT_W-1:0]         total_packets,
  output logic [CNT_W-1:0]         total_bytes
);

  localparam int unsigned KW    = DW / 8;
  localparam int unsigned PC_W  = $clog2(KW + 1);
  localparam int unsigned SUM_W = LEN_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic unused_tdata;
  assign unused_tdata = ^monitor_tdata;

  function automatic logic [PC_W-1:0] popcnt(input logic [KW-1:0] k);
    logic [PC_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < KW; i++) n = n + PC_W'(k[i]);
    return n;
  endfunction

  // Stage 1: capture the beat and its byte count
  logic            s1_valid;
  logic            s1_last;
  logic [PC_W-1:0] s1_cnt;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_cnt   <= '0;
    end else begin
      s1_valid <= monitor_tvalid & monitor_tready;
      s1_last  <= monitor_tlast;
      s1_cnt   <= popcnt(monitor_tkeep);
    end
  end

  // Stage 2: saturating length accumulation and bin compare
  logic [LEN_W-1:0] partial;
  logic             sat;
  logic [SUM_W-1:0] sum_c;
  logic [LEN_W-1:0] len_c;
  logic             sat_c;
  logic [NBINS-1:0] match_c;
  logic             found_c;

  assign sum_c = {1'b0, partial} + SUM_W'(s1_cnt);
  assign len_c = sum_c[LEN_W] ? LEN_MAX : sum_c[LEN_W-1:0];
  assign sat_c = sat | sum_c[LEN_W];

  // Lowest-index enabled bin whose length equals this packet's length
  always_comb begin
    match_c = '0;
    found_c = 1'b0;
    for (int unsigned k = 0; k < NBINS; k++) begin
      if (!found_c && (bin_len[k*LEN_W +: LEN_W] == len_c) &&
          (bin_len[k*LEN_W +: LEN_W] != '0)) begin
        match_c[k] = 1'b1;
        found_c    = 1'b1;
      end
    end
  end

  logic             s2_valid;
  logic [LEN_W-1:0] s2_len;
  logic             s2_sat;
  logic [NBINS-1:0] s2_match;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      partial  <= '0;
      sat      <= 1'b0;
      s2_valid <= 1'b0;
      s2_len   <= '0;
      s2_sat   <= 1'b0;
      s2_match <= '0;
    end else begin
      s2_valid <= 1'b0;
      if (s1_valid) begin
        if (s1_last) begin
          s2_valid <= 1'b1;
          s2_len   <= len_c;
          s2_sat   <= sat_c;
          s2_match <= match_c;
          partial  <= '0;
          sat      <= 1'b0;
        end else begin
          partial  <= len_c;
          sat      <= sat_c;
        end
      end
    end
  end

  // Stage 3: counter update; a clear on the same edge discards the update
  always_ff @(posedge clk) begin
    if (!aresetn || clear_counters) begin
      bin_packets      <= '0;
      other_packets    <= '0;
      oversize_packets <= '0;
      total_packets    <= '0;
      total_bytes      <= '0;
    end else if (s2_valid) begin
      total_packets <= total_packets + CNT_W'(1);
      total_bytes   <= total_bytes + CNT_W'(s2_len);
      if (s2_sat) begin
        oversize_packets <= oversize_packets + CNT_W'(1);
      end else if (|s2_match) begin
        for (int unsigned k = 0; k < NBINS; k++) begin
          if (s2_match[k])
            bin_packets[k*CNT_W +: CNT_W] <= bin_packets[k*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end else begin
        other_packets <= other_packets + CNT_W'(1);
      end
    end
  end

endmodule
